// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands.
// Operands arrive on one bus over two cycles; the product leaves as two words.
module booth_mult_seq #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] inBus,
    output logic             busy,
    output logic             outValid,
    output logic             done,
    output logic [WIDTH-1:0] outBus
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOADY,
        CALC,
        OUTHI,
        OUTLO
    } state_t;

    state_t state;
    state_t state_nx;

    // One guard bit on X, A and Y keeps the most negative operand exact.
    logic [WIDTH:0] x_reg;
    logic [WIDTH:0] a_reg;
    logic [WIDTH:0] y_reg;
    logic [WIDTH:0] sum;
    logic           y_m1;
    logic           mode;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        outValid = 1'b0;
        done     = 1'b0;
        outBus   = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = LOADY;
                end
            end
            LOADY: begin
                state_nx = CALC;
            end
            CALC: begin
                if (cnt == LAST) begin
                    state_nx = OUTHI;
                end
            end
            OUTHI: begin
                outValid = 1'b1;
                outBus   = {a_reg[WIDTH-2:0], y_reg[WIDTH]};
                state_nx = OUTLO;
            end
            OUTLO: begin
                outValid = 1'b1;
                done     = 1'b1;
                outBus   = y_reg[WIDTH-1:0];
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        sum = a_reg;
        case ({y_reg[0], y_m1})
            2'b01:   sum = a_reg + x_reg;
            2'b10:   sum = a_reg - x_reg;
            default: sum = a_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg <= '0;
            a_reg <= '0;
            y_reg <= '0;
            y_m1  <= 1'b0;
            mode  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg <= {sgn & inBus[WIDTH-1], inBus};
                        mode  <= sgn;
                    end
                end
                LOADY: begin
                    y_reg <= {mode & inBus[WIDTH-1], inBus};
                    a_reg <= '0;
                    y_m1  <= 1'b0;
                    cnt   <= '0;
                end
                CALC: begin
                    a_reg <= {sum[WIDTH], sum[WIDTH:1]};
                    y_reg <= {sum[0], y_reg[WIDTH:1]};
                    y_m1  <= y_reg[0];
                    cnt   <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: vector table, random operands against an
// arithmetic product model, and hand-written abort/overlap sequences.
module tb_booth_mult_seq;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sgn;
    logic [W-1:0] in_bus;
    logic         busy;
    logic         out_valid;
    logic         done;
    logic [W-1:0] out_bus;

    logic         start8;
    logic         sgn8;
    logic [7:0]   in8;
    logic         busy8;
    logic         ov8;
    logic         done8;
    logic [7:0]   out8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .sgn(sgn), .inBus(in_bus),
        .busy(busy), .outValid(out_valid), .done(done), .outBus(out_bus)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .inBus(in8),
        .busy(busy8), .outValid(ov8), .done(done8), .outBus(out8)
    );

    typedef struct {
        bit           s;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Exact product from integer arithmetic, truncated to 2*W bits.
    function automatic logic [2*W-1:0] model(input bit s, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        longint xv;
        longint yv;
        logic [63:0] p;
        xv = longint'(x);
        yv = longint'(y);
        if (s && x[W-1]) xv = xv - (64'sd1 <<< W);
        if (s && y[W-1]) yv = yv - (64'sd1 <<< W);
        p = 64'(xv * yv);
        return p[2*W-1:0];
    endfunction

    task automatic op_start(input bit s, input logic [W-1:0] x);
        @(negedge clk);
        start  = 1'b1;
        sgn    = s;
        in_bus = x;
    endtask

    // Runs from cycle 1 (LOADY) to cycle W+5, checking every cycle.
    task automatic op_body(input bit s, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit noise,
                           input bit hold, input bit hs,
                           input logic [W-1:0] hx);
        logic [2*W-1:0] p;
        p = model(s, x, y);
        @(negedge clk);
        chk("loady_busy", 32'(busy), 32'd1);
        chk("loady_valid", 32'(out_valid), 32'd0);
        start  = 1'b0;
        in_bus = y;
        for (int c = 2; c <= W + 2; c++) begin
            @(negedge clk);
            chk("calc_busy", 32'(busy), 32'd1);
            chk("calc_valid", 32'(out_valid), 32'd0);
            chk("calc_done", 32'(done), 32'd0);
            in_bus = W'($urandom);
            sgn    = 1'($urandom);
            start  = noise ? 1'($urandom) : 1'b0;
        end
        @(negedge clk);
        chk("hi_valid", 32'(out_valid), 32'd1);
        chk("hi_done", 32'(done), 32'd0);
        chk("hi_word", 32'(out_bus), 32'(p[2*W-1:W]));
        start  = hold;
        sgn    = hold ? hs : 1'b0;
        in_bus = hold ? hx : W'($urandom);
        @(negedge clk);
        chk("lo_valid", 32'(out_valid), 32'd1);
        chk("lo_done", 32'(done), 32'd1);
        chk("lo_word", 32'(out_bus), 32'(p[W-1:0]));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_bus", 32'(out_bus), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sgn    = 1'b0;
        in_bus = '0;
        start8 = 1'b0;
        sgn8   = 1'b0;
        in8    = '0;

        vecs[0] = '{1'b1, 6'h3D, 6'h05, 6'h3F, 6'h31};
        vecs[1] = '{1'b0, 6'h3F, 6'h3F, 6'h3E, 6'h01};
        vecs[2] = '{1'b1, 6'h3F, 6'h3F, 6'h00, 6'h01};
        vecs[3] = '{1'b1, 6'h20, 6'h20, 6'h10, 6'h00};
        vecs[4] = '{1'b0, 6'h02, 6'h03, 6'h00, 6'h06};
        vecs[5] = '{1'b0, 6'h3F, 6'h01, 6'h00, 6'h3F};
        vecs[6] = '{1'b1, 6'h01, 6'h3F, 6'h3F, 6'h3F};
        vecs[7] = '{1'b0, 6'h20, 6'h20, 6'h10, 6'h00};

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bus", 32'(out_bus), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", 32'(busy), 32'd0);

        // Table vectors, checked against the table's own expected words.
        for (int i = 0; i < 8; i++) begin
            logic [2*W-1:0] p;
            p = model(vecs[i].s, vecs[i].x, vecs[i].y);
            chk("table_model_hi", 32'(p[2*W-1:W]), 32'(vecs[i].hi));
            chk("table_model_lo", 32'(p[W-1:0]), 32'(vecs[i].lo));
            op_start(vecs[i].s, vecs[i].x);
            op_body(vecs[i].s, vecs[i].x, vecs[i].y, 1'b0, 1'b0, 1'b0, '0);
        end

        // Random operands, random start pulses while busy.
        for (int i = 0; i < 40; i++) begin
            bit s;
            logic [W-1:0] x;
            logic [W-1:0] y;
            s = 1'($urandom);
            x = W'($urandom);
            y = W'($urandom);
            op_start(s, x);
            op_body(s, x, y, 1'b1, 1'b0, 1'b0, '0);
        end

        // Start held through OUTHI/OUTLO: next op accepted only in IDLE.
        op_start(1'b1, 6'h3D);
        op_body(1'b1, 6'h3D, 6'h05, 1'b1, 1'b1, 1'b0, 6'h07);
        chk("held_start_idle", 32'(busy), 32'd0);
        op_body(1'b0, 6'h07, 6'h09, 1'b0, 1'b0, 1'b0, '0);

        // Reset in the middle of CALC aborts with no result words.
        op_start(1'b0, 6'h15);
        @(negedge clk);
        start  = 1'b0;
        in_bus = 6'h2A;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bus", 32'(out_bus), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < W + 6; c++) begin
            @(negedge clk);
            chk("post_abort_valid", 32'(out_valid), 32'd0);
            chk("post_abort_busy", 32'(busy), 32'd0);
        end
        op_start(1'b0, 6'h02);
        op_body(1'b0, 6'h02, 6'h03, 1'b0, 1'b0, 1'b0, '0);

        // WIDTH=8: 127 * -128 = 0xC080, words at cycles 11 and 12.
        @(negedge clk);
        start8 = 1'b1;
        sgn8   = 1'b1;
        in8    = 8'h7F;
        @(negedge clk);
        start8 = 1'b0;
        in8    = 8'h80;
        repeat (9) @(negedge clk);
        chk("w8_calc_valid", 32'(ov8), 32'd0);
        @(negedge clk);
        chk("w8_hi_valid", 32'(ov8), 32'd1);
        chk("w8_hi_word", 32'(out8), 32'h00C0);
        @(negedge clk);
        chk("w8_lo_done", 32'(done8), 32'd1);
        chk("w8_lo_word", 32'(out8), 32'h0080);
        @(negedge clk);
        chk("w8_idle_busy", 32'(busy8), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
